// File: rtl/uart_tx_buffered_pkg.sv
// Shared constants, FSM encodings and helpers for the buffered UART transmitter.
package uart_tx_buffered_pkg;

    localparam int          UART_FRAME_BITS = 10;
    localparam int          UART_DATA_BITS  = 8;
    localparam logic [31:0] UART_MIN_DIV    = 32'd2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // Divider values below the minimum would make a bit shorter than the FSM can track.
    function automatic logic [31:0] eff_period(input logic [31:0] div);
        return (div < UART_MIN_DIV) ? UART_MIN_DIV : div;
    endfunction

endpackage

// File: rtl/uart_tx_buffered_fifo.sv
// Synchronous TX byte FIFO; extra pointer bit distinguishes full from empty.
module uart_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic [WIDTH-1:0]         dout_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign level_o = wr_ptr_q - rd_ptr_q;
    assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

    // Full is judged on the registered pointers, so a pop cannot free a slot for the same edge.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din_i;
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: divider register, TX FIFO and bit-serialising FSM.
module uart_tx_buffered
    import uart_tx_buffered_pkg::*;
#(
    parameter logic [31:0] DEFAULT_DIV = 32'd106,
    parameter int          FIFO_DEPTH  = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [3:0]                   reg_div_we,
    input  logic [31:0]                  reg_div_di,
    output logic [31:0]                  reg_div_do,
    input  logic                         reg_dat_we,
    input  logic [31:0]                  reg_dat_di,
    output logic                         reg_dat_wait,
    output logic                         tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic                         ser_tx
);

    logic [31:0] div_q, div_d;
    logic [1:0]  state_q, state_d;
    logic [31:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic [31:0] period_q, period_d;
    logic        ser_q, ser_d;

    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_pop;
    logic [7:0]  fifo_dout;
    logic        bit_end;
    logic        unused_dat_hi;

    assign unused_dat_hi = ^reg_dat_di[31:8];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_div_lane
            assign div_d[gi*8 +: 8] = reg_div_we[gi] ? reg_div_di[gi*8 +: 8] : div_q[gi*8 +: 8];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q <= DEFAULT_DIV;
        end else begin
            div_q <= div_d;
        end
    end

    assign reg_div_do = div_q;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (reg_dat_we),
        .din_i   (reg_dat_di[7:0]),
        .pop_i   (fifo_pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level),
        .dout_o  (fifo_dout)
    );

    assign reg_dat_wait = reg_dat_we & fifo_full;
    assign bit_end      = (baud_q == period_q - 32'd1);

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q + 32'd1;
        bit_d    = bit_q;
        shift_d  = shift_q;
        period_d = period_q;
        fifo_pop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
                    period_d = eff_period(div_q);
                    bit_d    = '0;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'(UART_DATA_BITS - 1)) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            default: begin
                // Chain straight into the next start bit so queued bytes leave without an idle gap.
                if (bit_end) begin
                    baud_d = '0;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_dout;
                        period_d = eff_period(div_q);
                        bit_d    = '0;
                        state_d  = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
        endcase
    end

    always_comb begin
        case (state_q)
            ST_START: ser_d = 1'b0;
            ST_DATA:  ser_d = shift_q[0];
            default:  ser_d = 1'b1;
        endcase
    end

    // The line is driven from a flop so it never glitches; it trails the FSM by one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            period_q <= eff_period(DEFAULT_DIV);
            ser_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            period_q <= period_d;
            ser_q    <= ser_d;
        end
    end

    assign ser_tx  = ser_q;
    assign tx_busy = (fifo_level != '0) | (state_q != ST_IDLE);

endmodule
